// File: rtl/univ_shift_register.sv
// univ_shift_register
//   WIDTH-bit universal shift register driven by commands. Each command is a
//   start strobe plus a step count. A command can hold, shift or rotate left
//   or right, or parallel-load the register. Shift and rotate commands run
//   one bit per enabled clock, and the busy/done outputs report progress.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset (q=0, FSM to IDLE)
//   enable         step qualifier; low stalls a running shift/rotate
//   start          command strobe, accepted only in IDLE
//   mode           000 hold, 001 shl, 010 shr, 011 rol, 100 ror, 101 load,
//                  11x hold
//   amount         number of single-bit steps
//   load_data      parallel value for a LOAD command
//   serial_in      bit shifted in on each executed SHL/SHR step
//   q              register contents
//   serial_out_msb q[WIDTH-1]
//   serial_out_lsb q[0]
//   busy           high while steps are outstanding
//   done           one-cycle pulse when a command completes
module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [2:0]       mode_reg, mode_next;

  logic [WIDTH-1:0] shl_vec, shr_vec, rol_vec, ror_vec, step_vec;
  logic             is_step_cmd;

  // Single-step results for each direction. The end bits come either from
  // serial_in (shift) or from the opposite end of q (rotate).
  assign shl_vec[0]       = serial_in;
  assign rol_vec[0]       = q_reg[WIDTH-1];
  assign shr_vec[WIDTH-1] = serial_in;
  assign ror_vec[WIDTH-1] = q_reg[0];

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_step
      assign shl_vec[gi]   = q_reg[gi-1];
      assign rol_vec[gi]   = q_reg[gi-1];
      assign shr_vec[gi-1] = q_reg[gi];
      assign ror_vec[gi-1] = q_reg[gi];
    end
  endgenerate

  // A step uses the latched mode. The live mode input may change after the
  // command is accepted.
  always_comb begin
    step_vec = q_reg;
    case (mode_reg)
      MODE_SHL: step_vec = shl_vec;
      MODE_SHR: step_vec = shr_vec;
      MODE_ROL: step_vec = rol_vec;
      MODE_ROR: step_vec = ror_vec;
      default:  step_vec = q_reg;
    endcase
  end

  always_comb begin
    is_step_cmd = 1'b0;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: is_step_cmd = 1'b1;
      default:                                is_step_cmd = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    remaining_next = remaining_reg;
    mode_next      = mode_reg;
    case (state_reg)
      ST_IDLE: begin
        // Acceptance does not look at enable. A zero count or a hold-type
        // mode still produces a done pulse, so the handshake stays uniform.
        if (start) begin
          if (mode == MODE_LOAD) begin
            q_next     = load_data;
            state_next = ST_DONE;
          end else if (is_step_cmd && (amount != '0)) begin
            mode_next      = mode;
            remaining_next = amount;
            state_next     = ST_SHIFT;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (enable) begin
          q_next         = step_vec;
          remaining_next = remaining_reg - CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      q_reg         <= '0;
      remaining_reg <= '0;
      mode_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      remaining_reg <= remaining_next;
      mode_reg      <= mode_next;
    end
  end

  assign q              = q_reg;
  assign serial_out_msb = q_reg[WIDTH-1];
  assign serial_out_lsb = q_reg[0];
  assign busy           = (state_reg == ST_SHIFT);
  assign done           = (state_reg == ST_DONE);

endmodule
